shield_frame_buffer: RTL and testbench
======================================

# shield_frame_buffer

Responder side of the colorshield pixel-write interface. Opens a bounded INPUT window on request from the scan engine, asserts `ready`, and accepts `write_en`/`pixel_addr`/`pixel_value` writes into a back buffer. At window close it commits the back buffer to a front buffer in one cycle. The scan engine reads the front buffer through a registered port, so the display never shows a half-written frame.

## Interface
- `INPUT_CYCLES`, 16: length of the INPUT window in clk cycles; must be ≥ 1.
- `CLEAR_ON_FRAME`, 1: when 1, the back buffer is cleared after every commit; when 0, writes accumulate across frames.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `frame_start`  in  1  one-cycle pulse from the scan engine requesting an INPUT window.
- `write_en`  in  1  writer asserts to store `pixel_value` at `pixel_addr`; may be held high for the whole window.
- `pixel_addr`  in  6  `{x[2:0], y[2:0]}`.
- `pixel_value`  in  24  RGB, 8 bits per channel.
- `ready`  out  1  high exactly during the INPUT window.
- `rd_en`  in  1  scan-engine read strobe.
- `rd_addr`  in  6  front-buffer read address.
- `rd_data`  out  24  registered read data.
- `overrun`  out  1  one-cycle pulse when a `frame_start` is dropped.

## Operation
- FSM states:
  - IDLE to INPUT on `frame_start`.
  - INPUT to COMMIT when the window counter reaches `INPUT_CYCLES`.
  - COMMIT to IDLE unconditionally.
- `ready` = (state == INPUT), decoded from registered state.
- Write rule: back[`pixel_addr`] ← `pixel_value` and valid_back[`pixel_addr`] ← 1 on any edge where `ready && write_en`.
  - Repeated writes to one address in a window: last write wins.
  - Writes outside INPUT are ignored.
- COMMIT:
  - front ← back and valid_front ← valid_back, all 64 entries in parallel.
  - If `CLEAR_ON_FRAME`, valid_back ← 0 on the same edge; otherwise back is untouched.
- Read rule: on `rd_en`, `rd_data` ← valid_front[`rd_addr`] ? front[`rd_addr`] : 0. `rd_data` holds its value when `rd_en` is low.
- Pixels never written read as 24'h000000.
- `frame_start` outside IDLE: request dropped, `overrun` pulses on the next cycle, and the current window length is unchanged.
- Window counter width = $clog2(`INPUT_CYCLES`+1); the counter resets to 0 on entering INPUT.

## Timing
- Reset values: state IDLE, `ready` 0, `rd_data` 0, `overrun` 0, both valid masks 0, counter 0. Data arrays need no reset.
- `frame_start` sampled at edge k in IDLE:
  - `ready` = 1 for cycles k+1 … k+`INPUT_CYCLES`; writes are sampled at the edges ending those cycles.
  - COMMIT in cycle k+`INPUT_CYCLES`+1 with `ready` = 0.
  - IDLE from cycle k+`INPUT_CYCLES`+2; a new `frame_start` is accepted from that cycle.
- Read latency: 1 cycle from `rd_en` to `rd_data`.
  - A read sampled at the COMMIT edge returns the pre-commit front value.
  - New frame data is visible from the following read.
- Reset asserted mid-window: `ready` drops immediately (asynchronously), the window is abandoned, and both buffers read as empty.

## Structure
- Shared package `colorshield_pkg`:
  - Constants: `PIXEL_W`=24, `ADDR_W`=6, `NUM_PIXELS`=64.
  - Typedef `fb_state_t` with {IDLE, INPUT, COMMIT}.
- One natural sub-module, `pixel_store`:
  - 64×24 data array, 64-bit valid mask, single write port, bulk-clear input, parallel-load input.
  - Instantiated twice, as back and front.
- FSM, window counter, and overrun logic live in `shield_frame_buffer`.

## Test plan
- Reset state: release reset, then read addresses 0x00, 0x24, 0x3F → `rd_data` = 0 for all, `ready` = 0, `overrun` = 0.
- Single write and commit: pulse `frame_start`, hold `write_en` = 1 with addr 0x24 and value 24'hFFFFFF through the window → `ready` is high for exactly 16 cycles; after COMMIT, a read of 0x24 returns FFFFFF and a read of 0x23 returns 0.
- Clear-on-frame: with `CLEAR_ON_FRAME` = 1, a second window writes only 0x25 = 24'h00FF00 → reads return 0x24 = 0 and 0x25 = 00FF00.
  - With `CLEAR_ON_FRAME` = 0, the same sequence → 0x24 = FFFFFF and 0x25 = 00FF00.
- Last-wins and out-of-window writes:
  - Write 0x10 = 0x111111 then 0x10 = 0x222222 in one window → reads 0x222222.
  - A write presented with `ready` = 0 → no effect.
- Dropped request: pulse `frame_start` in INPUT cycle 5 → `overrun` pulses for one cycle, COMMIT still occurs at cycle k+17, and no second window opens.
- Read during COMMIT and reset mid-window:
  - `rd_en` on the COMMIT cycle → returns the old front value.
  - Assert `rst_n` low during INPUT → `ready` = 0 immediately, and after release all reads return 0.

Source files
------------

// File: rtl/colorshield_pkg.sv
// Shared colorshield constants, FSM state type and the packed pixel-array type
// used by the frame buffer and its pixel stores.
package colorshield_pkg;
    localparam int PIXEL_W    = 24;
    localparam int ADDR_W     = 6;
    localparam int NUM_PIXELS = 64;

    typedef enum logic [1:0] {IDLE, INPUT, COMMIT} fb_state_t;

    typedef logic [NUM_PIXELS-1:0][PIXEL_W-1:0] pixel_array_t;
endpackage

// File: rtl/shield_frame_buffer_if.sv
// Pixel-write and front-buffer read bus between the scan engine (master)
// and the frame buffer (slave).
interface shield_frame_buffer_if;
    import colorshield_pkg::*;

    logic               frame_start;
    logic               write_en;
    logic [ADDR_W-1:0]  pixel_addr;
    logic [PIXEL_W-1:0] pixel_value;
    logic               ready;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [PIXEL_W-1:0] rd_data;
    logic               overrun;

    modport master (
        output frame_start, write_en, pixel_addr, pixel_value, rd_en, rd_addr,
        input  ready, rd_data, overrun
    );

    modport slave (
        input  frame_start, write_en, pixel_addr, pixel_value, rd_en, rd_addr,
        output ready, rd_data, overrun
    );
endinterface

// File: rtl/shield_frame_buffer_pixel_store.sv
// 64-entry pixel array with a per-entry valid mask; one write port plus a
// whole-array parallel load and a bulk clear of the valid mask.
module pixel_store
    import colorshield_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [PIXEL_W-1:0]    wr_data,
    input  logic                  clear,
    input  logic                  load,
    input  pixel_array_t          load_data,
    input  logic [NUM_PIXELS-1:0] load_valid,
    output pixel_array_t          data,
    output logic [NUM_PIXELS-1:0] valid
);

    // Only the valid mask is reset; unwritten entries read through it as empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (load) begin
            valid <= load_valid;
        end else if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
        end else if (wr_en) begin
            data[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/shield_frame_buffer.sv
// Double-buffered colorshield frame buffer: writes land in the back store during
// a bounded INPUT window and are committed to the front store in one cycle.
module shield_frame_buffer
    import colorshield_pkg::*;
#(
    parameter int INPUT_CYCLES   = 16,
    parameter int CLEAR_ON_FRAME = 1
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    shield_frame_buffer_if.slave bus
);

    localparam int CNT_W = $clog2(INPUT_CYCLES + 1);

    fb_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  overrun_q;
    logic [PIXEL_W-1:0]    rd_data_p1;
    logic                  commit;
    logic                  back_wr;
    logic                  back_clear;
    pixel_array_t          back_data, front_data;
    logic [NUM_PIXELS-1:0] back_valid, front_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= bus.frame_start && (state_q != IDLE);
        end
    end

    // A frame_start seen outside IDLE is ignored here; it only raises overrun.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    state_d = INPUT;
                    cnt_d   = '0;
                end
            end
            INPUT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(INPUT_CYCLES)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign commit     = (state_q == COMMIT);
    assign back_wr    = (state_q == INPUT) && bus.write_en;
    assign back_clear = commit && (CLEAR_ON_FRAME != 0);

    pixel_store u_back (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (back_wr),
        .wr_addr    (bus.pixel_addr),
        .wr_data    (bus.pixel_value),
        .clear      (back_clear),
        .load       (1'b0),
        .load_data  ('0),
        .load_valid ('0),
        .data       (back_data),
        .valid      (back_valid)
    );

    pixel_store u_front (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (1'b0),
        .wr_addr    ('0),
        .wr_data    ('0),
        .clear      (1'b0),
        .load       (commit),
        .load_data  (back_data),
        .load_valid (back_valid),
        .data       (front_data),
        .valid      (front_valid)
    );

    // Read stage: sees the front store as it was before any same-edge commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1 <= '0;
        end else if (bus.rd_en) begin
            rd_data_p1 <= front_valid[bus.rd_addr] ? front_data[bus.rd_addr] : '0;
        end
    end

    assign bus.ready   = (state_q == INPUT);
    assign bus.rd_data = rd_data_p1;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_shield_frame_buffer.sv
// Bench for shield_frame_buffer: two instances (clear-on-frame and accumulate)
// share one stimulus stream and are compared against a pixel-level reference model.
module tb_shield_frame_buffer;
    import colorshield_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               frame_start = 1'b0;
    logic               write_en    = 1'b0;
    logic [ADDR_W-1:0]  pixel_addr  = '0;
    logic [PIXEL_W-1:0] pixel_value = '0;
    logic               rd_en       = 1'b0;
    logic [ADDR_W-1:0]  rd_addr     = '0;

    shield_frame_buffer_if bus_c ();
    shield_frame_buffer_if bus_a ();

    assign bus_c.frame_start = frame_start;
    assign bus_c.write_en    = write_en;
    assign bus_c.pixel_addr  = pixel_addr;
    assign bus_c.pixel_value = pixel_value;
    assign bus_c.rd_en       = rd_en;
    assign bus_c.rd_addr     = rd_addr;
    assign bus_a.frame_start = frame_start;
    assign bus_a.write_en    = write_en;
    assign bus_a.pixel_addr  = pixel_addr;
    assign bus_a.pixel_value = pixel_value;
    assign bus_a.rd_en       = rd_en;
    assign bus_a.rd_addr     = rd_addr;

    shield_frame_buffer #(.INPUT_CYCLES(N), .CLEAR_ON_FRAME(1)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c)
    );

    shield_frame_buffer #(.INPUT_CYCLES(N), .CLEAR_ON_FRAME(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    // Reference model: index 0 = clear-on-frame, index 1 = accumulate.
    logic [PIXEL_W-1:0] back_m  [2][NUM_PIXELS];
    bit                 back_v  [2][NUM_PIXELS];
    logic [PIXEL_W-1:0] front_m [2][NUM_PIXELS];
    bit                 front_v [2][NUM_PIXELS];
    logic [PIXEL_W-1:0] last_rd [2];

    bit                 plan_en   [N];
    logic [ADDR_W-1:0]  plan_addr [N];
    logic [PIXEL_W-1:0] plan_val  [N];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PIXEL_W-1:0] exp_front(input int v, input logic [ADDR_W-1:0] a);
        return front_v[v][a] ? front_m[v][a] : '0;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            last_rd[v] = '0;
            for (int a = 0; a < NUM_PIXELS; a++) begin
                back_v[v][a]  = 1'b0;
                front_v[v][a] = 1'b0;
            end
        end
    endtask

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [PIXEL_W-1:0] val);
        for (int v = 0; v < 2; v++) begin
            back_m[v][a] = val;
            back_v[v][a] = 1'b1;
        end
    endtask

    task automatic model_commit();
        for (int v = 0; v < 2; v++) begin
            for (int a = 0; a < NUM_PIXELS; a++) begin
                front_m[v][a] = back_m[v][a];
                front_v[v][a] = back_v[v][a];
                if (v == 0) back_v[v][a] = 1'b0;
            end
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++) begin
            plan_en[i]   = 1'b0;
            plan_addr[i] = '0;
            plan_val[i]  = '0;
        end
    endtask

    task automatic random_plan();
        for (int i = 0; i < N; i++) begin
            plan_en[i]   = ($urandom_range(3, 0) != 0);
            plan_addr[i] = ADDR_W'($urandom_range(23, 8));
            plan_val[i]  = PIXEL_W'($urandom);
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input string tag);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        for (int v = 0; v < 2; v++) last_rd[v] = exp_front(v, a);
        check({tag, "_clr"}, 32'(bus_c.rd_data), 32'(last_rd[0]));
        check({tag, "_acc"}, 32'(bus_a.rd_data), 32'(last_rd[1]));
    endtask

    task automatic hold_check();
        rd_en   = 1'b0;
        rd_addr = ADDR_W'($urandom);
        tick();
        check("rd_hold_clr", 32'(bus_c.rd_data), 32'(last_rd[0]));
        check("rd_hold_acc", 32'(bus_a.rd_data), 32'(last_rd[1]));
    endtask

    // Opens one window from IDLE, plays the write plan, optionally drops a
    // frame_start at window index drop_at and reads rd_a during the COMMIT cycle.
    task automatic run_window(input int drop_at, input int rd_a);
        logic [PIXEL_W-1:0] pre [2];
        check("ready_before", {bus_c.ready, bus_a.ready}, 32'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("ready_window", {bus_c.ready, bus_a.ready}, 32'd3);
            if (drop_at >= 0 && i == drop_at + 1)
                check("overrun_pulse", {bus_c.overrun, bus_a.overrun}, 32'd3);
            else
                check("overrun_quiet", {bus_c.overrun, bus_a.overrun}, 32'd0);
            write_en    = plan_en[i];
            pixel_addr  = plan_addr[i];
            pixel_value = plan_val[i];
            frame_start = (i == drop_at);
            tick();
            if (plan_en[i]) model_write(plan_addr[i], plan_val[i]);
        end
        write_en    = 1'b0;
        frame_start = 1'b0;
        check("ready_commit", {bus_c.ready, bus_a.ready}, 32'd0);
        check("overrun_commit", {bus_c.overrun, bus_a.overrun}, 32'd0);
        if (rd_a >= 0) begin
            rd_en   = 1'b1;
            rd_addr = ADDR_W'(rd_a);
            for (int v = 0; v < 2; v++) pre[v] = exp_front(v, ADDR_W'(rd_a));
        end
        tick();
        model_commit();
        if (rd_a >= 0) begin
            rd_en = 1'b0;
            for (int v = 0; v < 2; v++) last_rd[v] = pre[v];
            check("rd_at_commit_clr", 32'(bus_c.rd_data), 32'(pre[0]));
            check("rd_at_commit_acc", 32'(bus_a.rd_data), 32'(pre[1]));
        end
        check("ready_after", {bus_c.ready, bus_a.ready}, 32'd0);
    endtask

    initial begin
        model_reset();
        clear_plan();

        // Reset state
        tick();
        check("reset_ready", {bus_c.ready, bus_a.ready}, 32'd0);
        check("reset_overrun", {bus_c.overrun, bus_a.overrun}, 32'd0);
        check("reset_rd_data", 32'(bus_c.rd_data | bus_a.rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(6'h00, "reset_rd00");
        do_read(6'h24, "reset_rd24");
        do_read(6'h3F, "reset_rd3f");
        check("idle_ready", {bus_c.ready, bus_a.ready}, 32'd0);
        check("idle_overrun", {bus_c.overrun, bus_a.overrun}, 32'd0);

        // Single held write through the whole window
        for (int i = 0; i < N; i++) begin
            plan_en[i] = 1'b1; plan_addr[i] = 6'h24; plan_val[i] = 24'hFFFFFF;
        end
        run_window(-1, -1);
        do_read(6'h24, "win1_rd24");
        do_read(6'h23, "win1_rd23");
        hold_check();

        // Second frame writes only 0x25; read 0x24 during COMMIT
        for (int i = 0; i < N; i++) begin
            plan_en[i] = 1'b1; plan_addr[i] = 6'h25; plan_val[i] = 24'h00FF00;
        end
        run_window(-1, 'h24);
        do_read(6'h24, "win2_rd24");
        do_read(6'h25, "win2_rd25");

        // Writes outside a window are ignored
        write_en = 1'b1; pixel_addr = 6'h05; pixel_value = 24'hABCDEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_ready", {bus_c.ready, bus_a.ready}, 32'd0);
        end
        write_en = 1'b0;

        // Last write wins, plus a frame_start dropped in window cycle 5
        clear_plan();
        plan_en[0] = 1'b1; plan_addr[0] = 6'h10; plan_val[0] = 24'h111111;
        plan_en[1] = 1'b1; plan_addr[1] = 6'h10; plan_val[1] = 24'h222222;
        run_window(4, -1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_second_window", {bus_c.ready, bus_a.ready}, 32'd0);
        end
        do_read(6'h10, "lastwin_rd10");
        do_read(6'h05, "oow_rd05");
        do_read(6'h24, "accum_rd24");

        // Randomised frames
        for (int f = 0; f < 4; f++) begin
            random_plan();
            run_window((f % 2 == 0) ? int'($urandom_range(10, 0)) : -1,
                       int'($urandom_range(23, 8)));
            for (int r = 0; r < 6; r++) begin
                do_read(ADDR_W'($urandom_range(25, 6)), "rand_rd");
            end
            hold_check();
        end

        // Reset in the middle of a window
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        write_en = 1'b1; pixel_addr = 6'h30; pixel_value = 24'h123456;
        tick();
        tick();
        check("mid_ready", {bus_c.ready, bus_a.ready}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ready_async", {bus_c.ready, bus_a.ready}, 32'd0);
        check("rst_rd_data_async", 32'(bus_c.rd_data | bus_a.rd_data), 32'd0);
        write_en = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {bus_c.ready, bus_a.ready}, 32'd0);
        do_read(6'h30, "post_rst_rd30");
        do_read(6'h24, "post_rst_rd24");
        do_read(6'h25, "post_rst_rd25");
        do_read(6'h10, "post_rst_rd10");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
